// File: rtl/dpll_pkg.sv
// Shared types and constants for the DPLL control path and the NCO top.
package dpll_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REF_FIRST = 2'd1,
        NCO_FIRST = 2'd2
    } dpll_state_t;

    localparam int ERR_W_DEFAULT = 24;

    // Preset NCO increments at 12 MHz: ~1, 2, 4 and 8 Hz
    localparam int INC_1HZ = 358;
    localparam int INC_2HZ = 716;
    localparam int INC_4HZ = 1432;
    localparam int INC_8HZ = 2864;

endpackage

// File: rtl/dpll_phase_filter_edge_det.sv
// Rising-edge detector with an optional synchroniser chain in front.
module dpll_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic level_s;
    logic prev_r;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Metastability chain for inputs from another clock domain
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_r <= '0;
                end else begin
                    sync_r[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign level_s = sync_r[SYNC_STAGES-1];
        end else begin : g_direct
            assign level_s = d;
        end
    endgenerate

    // Previous level for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    assign pulse = level_s & ~prev_r;

endmodule

// File: rtl/dpll_phase_filter.sv
// Phase detector and PI loop filter producing the NCO increment word.
module dpll_phase_filter
    import dpll_pkg::*;
#(
    parameter int CENTER_INC = INC_1HZ,
    parameter int INC_MIN    = 100,
    parameter int INC_MAX    = 4000,
    parameter int ERR_W      = ERR_W_DEFAULT,
    parameter int KP_SHIFT   = 12,
    parameter int KI_SHIFT   = 16,
    parameter int LOCK_TOL   = 64,
    parameter int LOCK_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    ref_in,
    input  logic                    nco_msb,
    output logic [15:0]             phase_inc,
    output logic                    inc_valid,
    output logic                    locked,
    output logic signed [ERR_W-1:0] phase_err
);

    localparam int CW = ERR_W - 1;
    localparam int SW = ERR_W + 2;
    localparam int LW = $clog2(LOCK_COUNT + 1);

    localparam logic [CW-1:0]           CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0]           CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic signed [ERR_W-1:0] ERR_MAX  = {1'b0, CNT_MAX};
    localparam logic signed [ERR_W:0]   IMAX_W   = {2'b00, CNT_MAX};
    localparam logic signed [ERR_W:0]   IMIN_W   = -IMAX_W;
    localparam logic signed [SW-1:0]    CENTER_S = SW'(CENTER_INC);
    localparam logic signed [SW-1:0]    MIN_S    = SW'(INC_MIN);
    localparam logic signed [SW-1:0]    MAX_S    = SW'(INC_MAX);
    localparam logic signed [ERR_W-1:0] TOL_P    = ERR_W'(LOCK_TOL);
    localparam logic signed [ERR_W-1:0] TOL_N    = -TOL_P;
    localparam logic [LW-1:0]           LOCK_MAX = LW'(LOCK_COUNT);
    localparam logic [LW-1:0]           LOCK_ONE = LW'(1);
    localparam logic [15:0]             CENTER_W = 16'(CENTER_INC);
    localparam logic [15:0]             MIN_W    = 16'(INC_MIN);
    localparam logic [15:0]             MAX_W    = 16'(INC_MAX);

    logic                    ref_edge_s;
    logic                    nco_edge_s;
    dpll_state_t             state_r, state_s;
    logic [CW-1:0]           cnt_r, cnt_s;
    logic signed [ERR_W-1:0] cnt_err_s;
    logic                    upd_s;
    logic signed [ERR_W-1:0] err_s;
    logic                    upd_r;
    logic signed [ERR_W-1:0] integ_r;
    logic [LW-1:0]           lock_cnt_r;
    logic signed [ERR_W-1:0] prop_s, ki_s, integ_n_s;
    logic signed [ERR_W:0]   isum_s;
    logic signed [SW-1:0]    sum_s;
    logic [15:0]             inc_n_s;
    logic                    clamped_s;
    logic                    in_tol_s;
    logic [LW-1:0]           lock_n_s;

    dpll_edge_det #(.SYNC_STAGES(2)) u_ref_det (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ref_in),
        .pulse   (ref_edge_s)
    );

    dpll_edge_det #(.SYNC_STAGES(0)) u_nco_det (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (nco_msb),
        .pulse   (nco_edge_s)
    );

    assign cnt_err_s = {1'b0, cnt_r};

    // Measurement FSM state register; enable low parks it in IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else if (!enable) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: the closing edge always wins over a repeated opener
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (ref_edge_s && !nco_edge_s) begin
                    state_s = REF_FIRST;
                    cnt_s   = CNT_ONE;
                end else if (nco_edge_s && !ref_edge_s) begin
                    state_s = NCO_FIRST;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = IDLE;
                end
            end
            REF_FIRST: begin
                if (nco_edge_s || (!ref_edge_s && cnt_r == CNT_MAX)) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else if (ref_edge_s) begin
                    cnt_s = CNT_ONE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            NCO_FIRST: begin
                if (ref_edge_s || (!nco_edge_s && cnt_r == CNT_MAX)) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else if (nco_edge_s) begin
                    cnt_s = CNT_ONE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Update events and the signed error they carry
    always_comb begin
        upd_s = 1'b0;
        err_s = '0;
        case (state_r)
            IDLE: begin
                if (ref_edge_s && nco_edge_s) begin
                    upd_s = 1'b1;
                end else begin
                    upd_s = 1'b0;
                end
            end
            REF_FIRST: begin
                if (nco_edge_s) begin
                    upd_s = 1'b1;
                    err_s = cnt_err_s;
                end else if (ref_edge_s || cnt_r == CNT_MAX) begin
                    upd_s = 1'b1;
                    err_s = ERR_MAX;
                end else begin
                    upd_s = 1'b0;
                end
            end
            NCO_FIRST: begin
                if (ref_edge_s) begin
                    upd_s = 1'b1;
                    err_s = -cnt_err_s;
                end else if (nco_edge_s || cnt_r == CNT_MAX) begin
                    upd_s = 1'b1;
                    err_s = -ERR_MAX;
                end else begin
                    upd_s = 1'b0;
                end
            end
            default: begin
                upd_s = 1'b0;
            end
        endcase
    end

    // Pipeline stage 1: capture the error of each update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_err <= '0;
            upd_r     <= 1'b0;
        end else if (!enable) begin
            upd_r <= 1'b0;
        end else begin
            upd_r <= upd_s;
            if (upd_s) begin
                phase_err <= err_s;
            end
        end
    end

    assign prop_s = phase_err >>> KP_SHIFT;
    assign ki_s   = phase_err >>> KI_SHIFT;
    assign isum_s = {integ_r[ERR_W-1], integ_r} + {ki_s[ERR_W-1], ki_s};
    assign sum_s  = CENTER_S + {{2{prop_s[ERR_W-1]}}, prop_s}
                  + {{2{integ_n_s[ERR_W-1]}}, integ_n_s};

    // Integrator saturation and output clamp
    always_comb begin
        if (isum_s > IMAX_W) begin
            integ_n_s = ERR_MAX;
        end else if (isum_s < IMIN_W) begin
            integ_n_s = -ERR_MAX;
        end else begin
            integ_n_s = isum_s[ERR_W-1:0];
        end
        if (sum_s > MAX_S) begin
            inc_n_s   = MAX_W;
            clamped_s = 1'b1;
        end else if (sum_s < MIN_S) begin
            inc_n_s   = MIN_W;
            clamped_s = 1'b1;
        end else begin
            inc_n_s   = sum_s[15:0];
            clamped_s = 1'b0;
        end
    end

    // Lock counter next value, saturating at LOCK_COUNT
    always_comb begin
        in_tol_s = (phase_err <= TOL_P) && (phase_err >= TOL_N);
        if (!in_tol_s) begin
            lock_n_s = '0;
        end else if (lock_cnt_r == LOCK_MAX) begin
            lock_n_s = LOCK_MAX;
        end else begin
            lock_n_s = lock_cnt_r + LOCK_ONE;
        end
    end

    // Pipeline stage 2: filter state and outputs; integrator frozen while clamped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_inc  <= CENTER_W;
            inc_valid  <= 1'b0;
            locked     <= 1'b0;
            integ_r    <= '0;
            lock_cnt_r <= '0;
        end else if (!enable) begin
            phase_inc  <= CENTER_W;
            inc_valid  <= 1'b0;
            locked     <= 1'b0;
            integ_r    <= '0;
            lock_cnt_r <= '0;
        end else begin
            inc_valid <= upd_r;
            if (upd_r) begin
                phase_inc  <= inc_n_s;
                lock_cnt_r <= lock_n_s;
                locked     <= (lock_n_s == LOCK_MAX);
                if (!clamped_s) begin
                    integ_r <= integ_n_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_dpll_phase_filter.sv
// Self-checking bench for dpll_phase_filter: vector table, directed corners, random vs model.
module tb_dpll_phase_filter;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b0;
    logic               ref_in = 1'b0;
    logic               nco_msb = 1'b0;
    logic [15:0]        phase_inc;
    logic               inc_valid;
    logic               locked;
    logic signed [23:0] phase_err;

    dpll_phase_filter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .ref_in    (ref_in),
        .nco_msb   (nco_msb),
        .phase_inc (phase_inc),
        .inc_valid (inc_valid),
        .locked    (locked),
        .phase_err (phase_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int err;
        int inc;
        int lk;
    } exp_t;

    typedef struct {
        int err;
        int inc;
        int lk;
    } vec_t;

    localparam longint EMAX = 64'sd8388607;

    exp_t   expq[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     neg_cnt = 0;
    longint m_integ;
    int     m_lcnt;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (negedge %0d)", name, act, exp, neg_cnt);
    endtask

    // One cycle: sample at the negedge, compare against any expected update
    task automatic tick();
        @(negedge clk);
        neg_cnt++;
        if (expq.size() > 0 && expq[0].idx == neg_cnt) begin
            check("inc_valid_pulse", inc_valid, 1);
            check("phase_err", phase_err, expq[0].err);
            check("phase_inc", phase_inc, expq[0].inc);
            check("locked", locked, expq[0].lk);
            void'(expq.pop_front());
        end else begin
            check("inc_valid_idle", inc_valid, 0);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_integ = 0;
        m_lcnt  = 0;
    endtask

    task automatic model_step(input longint e, output int inc, output int lk);
        longint in, sum;
        in = m_integ + floor_div(e, 65536);
        if (in > EMAX) in = EMAX;
        if (in < -EMAX) in = -EMAX;
        sum = 358 + floor_div(e, 4096) + in;
        if (sum > 4000) inc = 4000;
        else if (sum < 100) inc = 100;
        else begin
            inc = int'(sum);
            m_integ = in;
        end
        if (e <= 64 && e >= -64) m_lcnt = (m_lcnt < 4) ? m_lcnt + 1 : 4;
        else m_lcnt = 0;
        lk = (m_lcnt == 4) ? 1 : 0;
    endtask

    task automatic push_exp(input int idx, input int e, input int inc, input int lk);
        exp_t x;
        x.idx = idx; x.err = e; x.inc = inc; x.lk = lk;
        expq.push_back(x);
    endtask

    // One measurement whose detected edges are |e| cycles apart (e<0: NCO leads).
    // ref_in has 2 cycles of synchroniser latency, nco_msb none.
    task automatic measure(input int e, input int tinc, input int tlk);
        int a, ro, no, minc, mlk;
        a = (e < 0) ? -e : e;
        if (e >= 0) begin ro = 0; no = e + 2; end
        else begin ro = a; no = 2; end
        model_step(e, minc, mlk);
        for (int k = 0; k <= a + 6; k++) begin
            tick();
            if (k == 0) push_exp(neg_cnt + a + 4, e, (tinc < 0) ? minc : tinc, (tinc < 0) ? mlk : tlk);
            ref_in  = (k >= ro && k < ro + 3);
            nco_msb = (k >= no && k < no + 3);
        end
    endtask

    // Reference edges only, gap cycles apart; every edge after the first saturates
    task automatic ref_only(input int n, input int gap);
        int minc, mlk;
        for (int k = 0; k <= (n - 1) * gap + 6; k++) begin
            tick();
            if (k % gap == 0 && k / gap >= 1 && k / gap < n) begin
                model_step(EMAX, minc, mlk);
                push_exp(neg_cnt + 4, int'(EMAX), minc, mlk);
            end
            ref_in = ((k % gap) < 3) && (k / gap < n);
        end
    endtask

    task automatic disable_cycle();
        tick();
        enable = 1'b0;
        repeat (3) tick();
        check("disabled_inc", phase_inc, 358);
        check("disabled_locked", locked, 0);
        model_reset();
        enable = 1'b1;
        repeat (3) tick();
    endtask

    vec_t lock_tbl[5];

    initial begin
        lock_tbl[0] = '{err: 10,  inc: 358, lk: 0};
        lock_tbl[1] = '{err: -20, inc: 356, lk: 0};
        lock_tbl[2] = '{err: 64,  inc: 357, lk: 0};
        lock_tbl[3] = '{err: -64, inc: 355, lk: 1};
        lock_tbl[4] = '{err: 65,  inc: 356, lk: 0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_phase_inc", phase_inc, 358);
        check("rst_inc_valid", inc_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_phase_err", phase_err, 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        model_reset();
        repeat (10) tick();
        check("idle_phase_inc", phase_inc, 358);
        check("idle_phase_err", phase_err, 0);

        // Coincident edges, then reference lead / NCO lead
        measure(0, 358, 0);
        measure(65536, 375, 0);
        measure(-4096, 357, 0);

        // Lock acquisition and loss from the vector table
        for (int i = 0; i < 5; i++) begin
            measure(lock_tbl[i].err, lock_tbl[i].inc, lock_tbl[i].lk);
        end

        // Random measurements against the model
        for (int i = 0; i < 14; i++) begin
            measure(int'($urandom_range(400)) - 200, -1, 0);
        end
        for (int i = 0; i < 3; i++) begin
            measure(int'($urandom_range(6000)) - 3000, -1, 0);
        end
        repeat (4) measure(5, -1, 0);
        check("relocked", locked, 1);

        // Enable dropped mid-measurement; closing edge must be ignored
        for (int k = 0; k <= 520; k++) begin
            tick();
            ref_in = (k < 3);
            if (k == 500) enable = 1'b0;
            nco_msb = (k >= 510 && k < 513);
        end
        check("en_low_inc", phase_inc, 358);
        check("en_low_locked", locked, 0);
        model_reset();
        enable = 1'b1;
        repeat (3) tick();
        measure(30, 358, 0);

        // NCO far too slow: saturating errors until the output clamps
        disable_cycle();
        ref_only(16, 40);
        check("clamp_inc", phase_inc, 4000);
        check("integ_frozen", dut.integ_r, 1524);
        disable_cycle();

        // Reset in the middle of a measurement
        tick();
        ref_in = 1'b1;
        repeat (10) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        ref_in = 1'b0;
        check("midrst_inc", phase_inc, 358);
        check("midrst_err", phase_err, 0);
        check("midrst_locked", locked, 0);
        reset_n = 1'b1;
        model_reset();
        repeat (10) tick();
        measure(-30, 356, 0);
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
